sw_debounce8: RTL and testbench
===============================

Name: sw_debounce8

Overview:
- Input-conditioning stage that sits directly upstream of the 8-to-3 priority encoder / 7-segment block.
- Takes the 8 raw board switches plus the enable switch, synchronises each one into the clock domain, and debounces each one independently.
- Drives clean, glitch-free x[7:0] and en into the combinational encoder.
- Provides a one-cycle change strobe for downstream logging or display refresh.

Parameters:
TICK_DIV, 50000, clk cycles per debounce sample tick (50 MHz -> 1 kHz); legal >= 1; 1 = tick every clk
STABLE_TICKS, 10, consecutive mismatching ticks required before an output flips; legal >= 1

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
sw  input  8  raw switch levels, asynchronous to clk
en_sw  input  1  raw enable switch, asynchronous to clk
x  output  8  debounced switch vector, feeds encoder x
en  output  1  debounced enable, feeds encoder en
chg  output  1  one-clk pulse on the edge where any of x/en changes
busy  output  1  high while any channel counter is non-zero

Behaviour:
- Reset: rst_n low asynchronously clears everything, and this holds until rst_n rises.
  - Cleared state: both sync stages, prescaler, all counters, x=8'h00, en=0, chg=0, busy=0.
  - Reset mid-debounce discards all progress; there is no partial carry-over.
- Channels: 9 identical channels (sw[7:0], en_sw). Each channel has a 2-flop synchroniser (s1 -> s2).
  - Synchroniser latency is 2 clk.
- Prescaler: free-running counter 0..TICK_DIV-1, wraps to 0.
  - tick = 1 for exactly the clk cycle in which prescaler == TICK_DIV-1.
  - Prescaler width = clog2(TICK_DIV), minimum 1 bit.
  - The prescaler is shared; it never stops or restarts except on reset.
- Per-channel counter cnt has width clog2(STABLE_TICKS+1). Evaluated every clk edge, with out = x[i] or en:
  - s2 == out: cnt <= 0, regardless of tick. Any bounce back restarts the count.
  - s2 != out, tick = 0: cnt holds.
  - s2 != out, tick = 1, cnt < STABLE_TICKS-1: cnt <= cnt+1.
  - s2 != out, tick = 1, cnt == STABLE_TICKS-1: out <= s2, cnt <= 0.
- Resulting latency: from the edge where s2 first differs from out to the output update is STABLE_TICKS ticks.
  - This is (STABLE_TICKS-1)*TICK_DIV+1 to STABLE_TICKS*TICK_DIV clk, plus 2 clk of synchroniser.
- chg:
  - Registered; asserted on the same edge that any output bit flips, deasserted next clk unless another flip occurs.
  - Several channels flipping on the same edge give a single 1-clk pulse.
  - chg never pulses without a change in {en, x}.
- busy = OR of (cnt != 0) over all channels. It is combinational from the registers; no extra flop.
- No ordering between channels: x may update one bit at a time. The encoder must tolerate intermediate codes, and it does, being combinational.
- Outputs change only on clk rising edges, except during asynchronous reset.

Test Plan (TICK_DIV=4, STABLE_TICKS=3):
- Release rst_n with sw=8'h00, en_sw=0 -> x=00, en=0, chg=0, busy=0 for 50 clk.
- Step sw=8'h80, en_sw=1 and hold -> x=80 and en=1 on the same edge, 11..14 clk after the step; exactly one chg pulse of 1 clk.
- Glitch: sw[2]=1 for 5 clk, then 0 -> x unchanged, chg never asserts, busy returns to 0 within 3 clk of the glitch ending.
- Bounce: sw[5] toggles every 3 clk for 40 clk, then settles at 1 -> x[5] rises exactly once, 11..14 clk after settling, with one chg pulse; no earlier x[5] change.
- Simultaneous: sw goes 8'h80 -> 8'h28 in one clk -> bits 7, 5 and 3 flip on the same edge to x=28, with a single 1-clk chg pulse.
- Reset mid-debounce: sw=8'hFF, assert rst_n low 6 clk after the step -> x=00, en=0, busy=0 immediately (asynchronous). After release with sw held, x=FF 11..14 clk later.

Source files
------------

// File: rtl/sw_debounce8.sv
// rtl/sw_debounce8.sv - nine-channel switch synchroniser and debouncer feeding the priority encoder
module sw_debounce8 #(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       en_sw,
  output logic [7:0] x,
  output logic       en,
  output logic       chg,
  output logic       busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [8:0]    s1;
  logic [8:0]    s2;
  logic [8:0]    out_q;
  logic [PW-1:0] pre;
  logic [CW-1:0] cnt [9];
  logic          tick;
  logic [8:0]    mism;
  logic [8:0]    flip;

  assign tick = (pre == PRE_LAST);
  assign mism = s2 ^ out_q;
  assign x    = out_q[7:0];
  assign en   = out_q[8];

  // A channel flips on the tick that completes its run of mismatching ticks.
  always_comb begin
    flip = '0;
    busy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      flip[i] = mism[i] & tick & (cnt[i] == CNT_LAST);
      busy    = busy | (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      pre   <= '0;
      out_q <= '0;
      chg   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1    <= {en_sw, sw};
      s2    <= s1;
      pre   <= tick ? '0 : pre + PW'(1);
      out_q <= out_q ^ flip;
      chg   <= |flip;
      for (int i = 0; i < 9; i++) begin
        if (!mism[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          cnt[i] <= flip[i] ? '0 : cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce8.sv
// tb/tb_sw_debounce8.sv - scoreboard bench for sw_debounce8 against a tick-counting reference model
module tb_sw_debounce8;

  localparam int TD = 4;
  localparam int ST = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       en_sw = 1'b0;
  logic [7:0] x;
  logic       en;
  logic       chg;
  logic       busy;

  sw_debounce8 #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .en_sw(en_sw),
    .x(x), .en(en), .chg(chg), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int chg_seen = 0;
  logic [10:0] exp_q [$];
  logic [8:0] raw_cur = '0;

  // Reference model: output flips once a mismatch run has spanned ST prescaler ticks.
  logic [8:0]  m_out;
  logic [8:0]  h1;
  logic [8:0]  h2;
  int unsigned e_idx;
  bit          run [9];
  int unsigned start [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_checks++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, v, lo, hi, $time);
    end
  endtask

  function automatic int unsigned ticks_in(input int unsigned a, input int unsigned b);
    return (b + 1) / TD - a / TD;
  endfunction

  task automatic model_reset();
    m_out = '0;
    h1    = '0;
    h2    = '0;
    e_idx = 0;
    for (int i = 0; i < 9; i++) begin
      run[i]   = 1'b0;
      start[i] = 0;
    end
  endtask

  task automatic model_step(input logic [8:0] r);
    logic [8:0]  s2v;
    logic        f;
    logic        b;
    int unsigned t;
    s2v = h2;
    f = 1'b0;
    b = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (s2v[i] == m_out[i]) begin
        run[i] = 1'b0;
      end else begin
        if (!run[i]) begin
          run[i]   = 1'b1;
          start[i] = e_idx;
        end
        t = ticks_in(start[i], e_idx);
        if (t == ST) begin
          m_out[i] = s2v[i];
          run[i]   = 1'b0;
          f        = 1'b1;
        end else if (t > 0) begin
          b = 1'b1;
        end
      end
    end
    exp_q.push_back({f, m_out, b});
    h2 = h1;
    h1 = r;
    e_idx++;
  endtask

  task automatic drive(input logic [8:0] r);
    raw_cur = r;
    sw      = r[7:0];
    en_sw   = r[8];
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    #1;
    model_step(raw_cur);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) tick_cycle();
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_x", {24'h0, x}, 32'h0);
    check("async_reset_en_busy_chg", {29'h0, en, busy, chg}, 32'h0);
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_x(input logic [7:0] target, output int lat);
    bit found;
    found = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      if (!found) begin
        tick_cycle();
        if (x == target) begin
          found = 1'b1;
          lat = k;
        end
      end
    end
  endtask

  // Monitor: every settled cycle compares the DUT against the oldest expectation.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {21'h0, chg, en, x, busy}, {21'h0, e});
      end
      if (rst_n && chg) chg_seen++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [8:0] r;
    model_reset();
    drive(9'h000);
    @(posedge clk);
    #1;
    check("reset_outputs", {20'h0, x, en, busy, chg}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    cycles(50);
    check("idle_after_50", {22'h0, x, en, busy}, 32'h0);

    // Step
    chg_seen = 0;
    drive(9'h180);
    wait_x(8'h80, lat);
    check_range("step_latency", lat, 11, 14);
    check("step_en_same_edge", {31'h0, en}, 32'h1);
    cycles(6);
    check("step_single_chg", chg_seen, 1);

    // Glitch
    cycles(10);
    drive(9'h184);
    cycles(5);
    chg_seen = 0;
    drive(9'h180);
    cycles(3);
    check("glitch_busy_clear", {31'h0, busy}, 32'h0);
    cycles(15);
    check("glitch_x_unchanged", {24'h0, x}, 32'h80);
    check("glitch_no_chg", chg_seen, 0);

    // Bounce
    chg_seen = 0;
    for (int j = 0; j < 14; j++) begin
      drive((j % 2 == 0) ? 9'h1A0 : 9'h180);
      cycles(3);
    end
    check("bounce_x_held", {24'h0, x}, 32'h80);
    check("bounce_no_early_chg", chg_seen, 0);
    drive(9'h1A0);
    wait_x(8'hA0, lat);
    check_range("bounce_latency", lat, 11, 14);
    cycles(6);
    check("bounce_single_chg", chg_seen, 1);

    // Simultaneous
    drive(9'h180);
    cycles(20);
    chg_seen = 0;
    drive(9'h128);
    wait_x(8'h28, lat);
    check_range("simul_latency", lat, 11, 14);
    cycles(6);
    check("simul_single_chg", chg_seen, 1);

    // Reset mid-debounce
    drive(9'h1FF);
    cycles(6);
    do_reset(3);
    wait_x(8'hFF, lat);
    check_range("post_reset_latency", lat, 11, 14);
    cycles(6);

    // Randomized sparse toggling with occasional resets
    r = raw_cur;
    for (int s = 0; s < 150; s++) begin
      r = r ^ 9'($urandom & $urandom & $urandom);
      drive(r);
      cycles($urandom_range(1, 18));
      if (s % 50 == 49) do_reset($urandom_range(1, 4));
    end

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
